// File: rtl/speed_actuator_if.sv
// ============================================================================
// Module   : speed_actuator_if
// Purpose  : Command/status bundle between the drive FSM and speed_actuator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface speed_actuator_if;
    logic       accelerate_car;
    logic       unlock_req;
    logic [7:0] car_speed;
    logic       tick;
    logic       stopped;
    logic       door_unlock;
    logic [1:0] motion_state;

    modport master (
        output accelerate_car,
        output unlock_req,
        input  car_speed,
        input  tick,
        input  stopped,
        input  door_unlock,
        input  motion_state
    );

    modport slave (
        input  accelerate_car,
        input  unlock_req,
        output car_speed,
        output tick,
        output stopped,
        output door_unlock,
        output motion_state
    );
endinterface

`default_nettype wire

// File: rtl/speed_actuator.sv
// ============================================================================
// Module   : speed_actuator
// Purpose  : Rate-limited speed ramp and gated door-unlock strobe driven by
//            accelerate/unlock commands from the drive FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module speed_actuator #(
    parameter int TICK_DIV     = 16,
    parameter int ACCEL_STEP   = 2,
    parameter int DECEL_STEP   = 1,
    parameter int BRAKE_STEP   = 4,
    parameter int MAX_SPEED    = 200,
    parameter int UNLOCK_DELAY = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    speed_actuator_if.slave bus
);

    localparam int c_PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_CNT_W   = $clog2(UNLOCK_DELAY + 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_MAX    = c_CNT_W'(UNLOCK_DELAY);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'b00,
        ST_ACCEL   = 2'b01,
        ST_DECEL   = 2'b10,
        ST_BRAKE   = 2'b11
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_PRESC_W-1:0]   r_presc;
    logic                   w_tick;
    logic [7:0]             r_speed;
    logic [7:0]             w_speed_nxt;
    logic [8:0]             w_sum;
    logic                   r_stopped;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_door;
    logic                   w_unlock_ok;

    assign w_tick = (r_presc == c_PRESC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Unlock outranks accelerate in every state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_STOPPED: begin
                if (bus.accelerate_car && !bus.unlock_req) w_state_nxt = ST_ACCEL;
            end
            ST_ACCEL: begin
                if (bus.unlock_req)           w_state_nxt = ST_BRAKE;
                else if (!bus.accelerate_car) w_state_nxt = ST_DECEL;
            end
            ST_DECEL: begin
                if (bus.unlock_req)          w_state_nxt = ST_BRAKE;
                else if (bus.accelerate_car) w_state_nxt = ST_ACCEL;
                else if (r_speed == 8'd0)    w_state_nxt = ST_STOPPED;
            end
            ST_BRAKE: begin
                if (!bus.unlock_req && bus.accelerate_car) w_state_nxt = ST_ACCEL;
                else if (r_speed == 8'd0)                  w_state_nxt = ST_STOPPED;
                else if (!bus.unlock_req)                  w_state_nxt = ST_DECEL;
            end
            default: w_state_nxt = ST_STOPPED;
        endcase
    end

    // 9-bit sum so the clamp catches results beyond 255 as well.
    assign w_sum = {1'b0, r_speed} + 9'(ACCEL_STEP);

    always_comb begin
        w_speed_nxt = r_speed;
        if (w_tick) begin
            case (r_state)
                ST_ACCEL: w_speed_nxt = (w_sum > 9'(MAX_SPEED)) ? 8'(MAX_SPEED) : w_sum[7:0];
                ST_DECEL: w_speed_nxt = (r_speed >= 8'(DECEL_STEP)) ? r_speed - 8'(DECEL_STEP) : 8'd0;
                ST_BRAKE: w_speed_nxt = (r_speed >= 8'(BRAKE_STEP)) ? r_speed - 8'(BRAKE_STEP) : 8'd0;
                default:  w_speed_nxt = 8'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_STOPPED;
            r_speed   <= 8'd0;
            r_stopped <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_speed   <= w_speed_nxt;
            r_stopped <= (w_state_nxt == ST_STOPPED);
        end
    end

    assign w_unlock_ok = (r_state == ST_STOPPED) && bus.unlock_req && (r_speed == 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_door <= 1'b0;
        end else begin
            if (!w_unlock_ok) begin
                r_cnt <= '0;
            end else if (w_tick && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_door <= w_unlock_ok && (r_cnt == c_CNT_MAX);
        end
    end

    assign bus.car_speed    = r_speed;
    assign bus.tick         = w_tick;
    assign bus.stopped      = r_stopped;
    assign bus.door_unlock  = r_door;
    assign bus.motion_state = r_state;

endmodule

`default_nettype wire
